interrupt_controller: RTL and testbench

//  Collects interrupt events (I/O input, disk completion, user-quantum expiry), prioritises them and drives

---
 rtl/interrupt_controller.sv | 173 +++++++++++++++++
 tb/tb_interrupt_controller.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
`default_nettype none
// ============================================================================
//  Module      : interrupt_controller
//  Description : Latches io/disk/quantum events, prioritises them and raises
//                intr toward the control unit with a request/ack/clear
//                handshake. Owns the user-mode preemption quantum timer.
//  Revision    : 1.0  initial release
// ============================================================================
module interrupt_controller #(
    parameter int QW       = 16,
    parameter int QDEFAULT = 1000,
    parameter int CW       = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          userMode,
    input  logic          kernelMode,
    input  logic          io_req,
    input  logic          disk_done,
    input  logic          inta,
    input  logic          clearIntr,
    input  logic          quantum_load,
    input  logic [QW-1:0] quantum_value,
    output logic          intr,
    output logic [CW-1:0] intr_code,
    output logic          user_active,
    output logic [2:0]    pending
);

    localparam logic [QW-1:0] c_q_one     = QW'(1);
    localparam logic [QW-1:0] c_q_default = QW'(QDEFAULT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            r_intr;
    logic            w_intr_next;
    logic [CW-1:0]   r_code;
    logic [CW-1:0]   w_code_next;
    logic            r_user_active;
    logic            w_user_next;
    logic [2:0]      r_pending;
    logic [2:0]      w_pending_next;
    logic [2:0]      w_clear_mask;
    logic [QW-1:0]   r_counter;
    logic [QW-1:0]   w_counter_next;
    logic [QW-1:0]   r_qreg;
    logic [1:0]      w_best;
    logic            w_ack;
    logic            w_decrement;
    logic            w_expire;

    // Acknowledge only counts while a request is outstanding; a coincident
    // kernelMode withdraws the request instead.
    assign w_ack       = (r_state == S_REQ) & inta & ~kernelMode;
    assign w_decrement = r_user_active & (r_counter != '0) & ~w_ack;
    assign w_expire    = ~userMode & w_decrement & (r_counter == c_q_one);

    always_comb begin
        w_best = 2'd0;
        if (r_pending[0]) begin
            w_best = 2'd1;
        end else if (r_pending[1]) begin
            w_best = 2'd2;
        end else if (r_pending[2]) begin
            w_best = 2'd3;
        end
    end

    always_comb begin
        w_clear_mask = 3'b000;
        if (w_ack) begin
            case (r_code[1:0])
                2'd1:    w_clear_mask = 3'b001;
                2'd2:    w_clear_mask = 3'b010;
                2'd3:    w_clear_mask = 3'b100;
                default: w_clear_mask = 3'b000;
            endcase
        end
    end

    // New events are OR-ed in after the clear so a same-cycle event survives.
    assign w_pending_next = (r_pending & ~w_clear_mask) | {w_expire, disk_done, io_req};

    always_comb begin
        w_user_next = r_user_active;
        if (kernelMode | w_ack) begin
            w_user_next = 1'b0;
        end else if (userMode) begin
            w_user_next = 1'b1;
        end
    end

    // A zero quantum loads a zero count, which never expires.
    always_comb begin
        w_counter_next = r_counter;
        if (userMode) begin
            w_counter_next = r_qreg;
        end else if (w_decrement) begin
            w_counter_next = r_counter - c_q_one;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_intr_next  = r_intr;
        w_code_next  = r_code;
        case (r_state)
            S_IDLE: begin
                if (r_user_active & ~kernelMode & (|r_pending)) begin
                    w_state_next = S_REQ;
                    w_intr_next  = 1'b1;
                    w_code_next  = {{(CW-2){1'b0}}, w_best};
                end
            end
            S_REQ: begin
                if (kernelMode) begin
                    w_state_next = S_IDLE;
                    w_intr_next  = 1'b0;
                    w_code_next  = '0;
                end else if (inta) begin
                    w_state_next = S_SERVICE;
                    w_intr_next  = 1'b0;
                end
            end
            S_SERVICE: begin
                if (clearIntr) begin
                    w_state_next = S_IDLE;
                    w_code_next  = '0;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_intr_next  = 1'b0;
                w_code_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_intr        <= 1'b0;
            r_code        <= '0;
            r_user_active <= 1'b0;
            r_pending     <= 3'b000;
            r_counter     <= '0;
            r_qreg        <= c_q_default;
        end else begin
            r_state       <= w_state_next;
            r_intr        <= w_intr_next;
            r_code        <= w_code_next;
            r_user_active <= w_user_next;
            r_pending     <= w_pending_next;
            r_counter     <= w_counter_next;
            if (quantum_load) begin
                r_qreg <= quantum_value;
            end
        end
    end

    assign intr        = r_intr;
    assign intr_code   = r_code;
    assign user_active = r_user_active;
    assign pending     = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_interrupt_controller
//  Description : Scoreboard bench for interrupt_controller with a
//                transaction-level reference model and directed scenarios.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_interrupt_controller;

    localparam int QW = 16;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          userMode = 1'b0;
    logic          kernelMode = 1'b0;
    logic          io_req = 1'b0;
    logic          disk_done = 1'b0;
    logic          inta = 1'b0;
    logic          clearIntr = 1'b0;
    logic          quantum_load = 1'b0;
    logic [QW-1:0] quantum_value = '0;
    logic          intr;
    logic [CW-1:0] intr_code;
    logic          user_active;
    logic [2:0]    pending;

    interrupt_controller #(.QW(QW), .QDEFAULT(1000), .CW(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .userMode      (userMode),
        .kernelMode    (kernelMode),
        .io_req        (io_req),
        .disk_done     (disk_done),
        .inta          (inta),
        .clearIntr     (clearIntr),
        .quantum_load  (quantum_load),
        .quantum_value (quantum_value),
        .intr          (intr),
        .intr_code     (intr_code),
        .user_active   (user_active),
        .pending       (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        intr;
        logic [31:0] code;
        logic        ua;
        logic [2:0]  pend;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: the processor view (user/kernel), whether a request
    // is raised or being serviced, the event set and the remaining quantum.
    bit         m_user, m_intr, m_svc;
    int         m_code, m_qreg, m_count;
    logic [2:0] m_pend;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_step();
        bit         ack, withdraw, ticking, expire, n_user;
        int         n_count;
        logic [2:0] n_pend;
        if (reset) begin
            m_user = 0; m_intr = 0; m_svc = 0; m_code = 0;
            m_pend = 3'b000; m_qreg = 1000; m_count = 0;
            return;
        end
        ack      = m_intr && inta && !kernelMode;
        withdraw = m_intr && kernelMode;
        ticking  = m_user && (m_count > 0) && !ack;
        expire   = !userMode && ticking && (m_count == 1);
        n_count  = userMode ? m_qreg : (ticking ? m_count - 1 : m_count);
        n_pend   = m_pend;
        if (ack) n_pend[m_code-1] = 1'b0;
        n_pend   = n_pend | {expire, disk_done, io_req};
        n_user   = kernelMode ? 1'b0 : (ack ? 1'b0 : (userMode ? 1'b1 : m_user));
        if (m_intr) begin
            if (withdraw) begin
                m_intr = 0; m_code = 0;
            end else if (ack) begin
                m_intr = 0; m_svc = 1;
            end
        end else if (m_svc) begin
            if (clearIntr) begin
                m_svc = 0; m_code = 0;
            end
        end else if (m_user && !kernelMode && m_pend != 3'b000) begin
            m_intr = 1;
            m_code = m_pend[0] ? 1 : (m_pend[1] ? 2 : 3);
        end
        m_pend  = n_pend;
        m_user  = n_user;
        m_count = n_count;
        if (quantum_load) m_qreg = int'(quantum_value);
    endfunction

    task automatic drive(input bit rs, um, km, io, dk, ia, ci, ql, input int qv);
        exp_t e;
        @(negedge clk);
        reset = rs; userMode = um; kernelMode = km; io_req = io; disk_done = dk;
        inta = ia; clearIntr = ci; quantum_load = ql; quantum_value = QW'(qv);
        model_step();
        e.intr = m_intr; e.code = 32'(m_code); e.ua = m_user; e.pend = m_pend;
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic user_in();  drive(0, 1, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic kern_in();  drive(0, 0, 1, 0, 0, 0, 0, 0, 0); endtask
    task automatic ack();      drive(0, 0, 0, 0, 0, 1, 0, 0, 0); endtask
    task automatic clr();      drive(0, 0, 0, 0, 0, 0, 1, 0, 0); endtask
    task automatic load_q(input int v); drive(0, 0, 0, 0, 0, 0, 0, 1, v); endtask

    // Directed absolute check of the edge that samples the last driven inputs.
    task automatic expect_out(input string name, input bit ei, input int ec, input bit eu, input int ep);
        @(posedge clk);
        #2;
        check({name, ".intr"}, 64'(intr), 64'(ei));
        check({name, ".code"}, 64'(intr_code), 64'(ec));
        check({name, ".ua"},   64'(user_active), 64'(eu));
        check({name, ".pend"}, 64'(pending), 64'(ep));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("sb.intr", 64'(intr), 64'(e.intr));
                check("sb.code", 64'(intr_code), 64'(e.code));
                check("sb.ua",   64'(user_active), 64'(e.ua));
                check("sb.pend", 64'(pending), 64'(e.pend));
            end
        end
    end

    initial begin : stimulus
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("reset", 0, 0, 0, 0);

        // quantum of 5 cycles
        load_q(5);
        user_in();
        idle(4);
        idle(1);  expect_out("q_expire", 0, 0, 1, 4);
        idle(1);  expect_out("q_intr", 1, 3, 1, 4);
        ack();    expect_out("q_ack", 0, 3, 0, 0);
        clr();    expect_out("q_clear", 0, 0, 0, 0);

        // io and disk together: io first, disk on the next user entry
        load_q(0);
        user_in();
        drive(0, 0, 0, 1, 1, 0, 0, 0, 0); expect_out("both_pend", 0, 0, 1, 3);
        idle(1);  expect_out("both_intr", 1, 1, 1, 3);
        ack();    expect_out("both_ack", 0, 1, 0, 2);
        clr();    expect_out("both_clr", 0, 0, 0, 2);
        user_in(); expect_out("disk_ua", 0, 0, 1, 2);
        idle(1);  expect_out("disk_intr", 1, 2, 1, 2);
        ack();
        clr();    expect_out("disk_done", 0, 0, 0, 0);

        // masked in kernel mode, raised two cycles after user entry
        kern_in();
        drive(0, 0, 0, 1, 0, 0, 0, 0, 0);
        idle(3);  expect_out("kern_mask", 0, 0, 0, 1);
        user_in(); expect_out("km_um", 0, 0, 1, 1);
        idle(1);  expect_out("km_intr", 1, 1, 1, 1);
        drive(0, 0, 0, 1, 0, 1, 0, 0, 0); expect_out("ack_io", 0, 1, 0, 1);
        clr();    expect_out("ack_io_clr", 0, 0, 0, 1);
        user_in();
        idle(1);  expect_out("io_again", 1, 1, 1, 1);
        ack();
        clr();    expect_out("io_again_clr", 0, 0, 0, 0);

        // request withdrawn by kernelMode
        drive(0, 1, 0, 1, 0, 0, 0, 0, 0);
        idle(1);  expect_out("wd_req", 1, 1, 1, 1);
        kern_in(); expect_out("withdraw", 0, 0, 0, 1);
        user_in();
        idle(1);
        ack();
        clr();    expect_out("wd_clr", 0, 0, 0, 0);

        drive(0, 1, 1, 0, 0, 0, 0, 0, 0); expect_out("um_km", 0, 0, 0, 0);

        // zero quantum never preempts
        user_in();
        idle(2000); expect_out("no_q", 0, 0, 1, 0);
        kern_in();

        // reset while in service restores the default quantum
        load_q(3);
        user_in();
        idle(4);  expect_out("svc_req", 1, 3, 1, 4);
        ack();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0); expect_out("svc_reset", 0, 0, 0, 0);
        user_in();
        idle(999); expect_out("qdef_wait", 0, 0, 1, 0);
        idle(1);   expect_out("qdef_exp", 0, 0, 1, 4);
        idle(1);   expect_out("qdef_intr", 1, 3, 1, 4);
        ack();
        clr();

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bit rs, um, km, io, dk, ia, ci, ql;
            rs = ($urandom % 1000) == 0;
            um = m_user ? (($urandom % 100) == 0) : (($urandom % 10) == 0);
            km = ($urandom % 40) == 0;
            io = ($urandom % 30) == 0;
            dk = ($urandom % 30) == 0;
            ia = m_intr ? (($urandom % 4) == 0) : (($urandom % 50) == 0);
            ci = m_svc ? (($urandom % 4) == 0) : (($urandom % 50) == 0);
            ql = ($urandom % 60) == 0;
            drive(rs, um, km, io, dk, ia, ci, ql, int'($urandom_range(0, 25)));
        end
        idle(2);
        repeat (3) @(posedge clk);
        #5;
        check("sb_drain", 64'(sb_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
